// File: rtl/demux1to16_deserializer_pkg.sv
// Shared types and default sizing for the 1:16 serial-to-parallel deserializer.
package demux_deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;
  localparam int DEF_ERR_W = 8;

  localparam int LAST_SEL = DEF_WIDTH - 1;

  // Index of the final lane for a given word width, sized to the lane index.
  function automatic logic [DEF_SEL_W-1:0] last_sel(input int width);
    return DEF_SEL_W'(width - 1);
  endfunction

endpackage

// File: rtl/demux1to16_deserializer_if.sv
// Serial-in / word-out bus of the deserializer. master = link + consumer side, slave = the block.
interface demux1to16_deserializer_if
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int ERR_W = DEF_ERR_W
);
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic             frame_start;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [ERR_W-1:0] frame_err;

  modport master (
    output din, din_valid, frame_start, dout_ready,
    input  din_ready, sel, dout, dout_valid, frame_err
  );

  modport slave (
    input  din, din_valid, frame_start, dout_ready,
    output din_ready, sel, dout, dout_valid, frame_err
  );
endinterface

// File: rtl/demux1to16_deserializer_out_reg.sv
// Output word register: loads a completed word, holds it until the consumer takes it.
module deser_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  // A load wins over a same-cycle consume so back-to-back words keep valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= load_data;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to16_deserializer.sv
// 1:16 deserializer: steers each accepted serial bit into lane sel, emits full words
// on a valid/ready register, and counts words aborted by an early frame_start.
module demux1to16_deserializer
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic clk,
  input  logic rst,
  demux1to16_deserializer_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [WIDTH-1:0]   collect_q, collect_d;
  logic [ERR_W-1:0]   frame_err_q;
  logic [WIDTH-1:0]   dout_w;
  logic               dout_valid_w;

  logic din_ready, accept;
  logic first_lane;  // write lane 0 of a fresh word, sel -> 1
  logic restart;     // early frame_start aborts the partial word
  logic complete;    // last lane accepted, word goes to the output register
  logic wr_lane;     // ordinary write of lane sel

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: only the first framed bit leaves IDLE; only reset returns there.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept && bus.frame_start) state_d = COLLECT;
  end

  // Output/control decode: backpressure only when the last lane would overwrite an unconsumed word.
  always_comb begin
    din_ready  = !(state_q == COLLECT && sel_q == LAST && dout_valid_w && !bus.dout_ready);
    accept     = bus.din_valid && din_ready;
    first_lane = 1'b0;
    restart    = 1'b0;
    complete   = 1'b0;
    wr_lane    = 1'b0;
    case (state_q)
      IDLE:    first_lane = accept && bus.frame_start;
      COLLECT: begin
        if (accept) begin
          if (bus.frame_start && sel_q != '0) begin
            restart    = 1'b1;
            first_lane = 1'b1;
          end else if (sel_q == LAST) begin
            complete = 1'b1;
          end else begin
            wr_lane = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Per-lane next value. Lanes at or above sel are always zero, so clearing the
  // whole register on a restart is the same as clearing lanes 1..sel-1.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    always_comb begin
      collect_d[k] = collect_q[k];
      if (first_lane)                              collect_d[k] = (k == 0) ? bus.din : 1'b0;
      else if (complete)                           collect_d[k] = 1'b0;
      else if (wr_lane && sel_q == SEL_W'(k))      collect_d[k] = bus.din;
    end
  end

  // Collect register and lane counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collect_q <= '0;
      sel_q     <= '0;
    end else begin
      collect_q <= collect_d;
      if (first_lane)    sel_q <= SEL_W'(1);
      else if (complete) sel_q <= '0;
      else if (wr_lane)  sel_q <= sel_q + SEL_W'(1);
    end
  end

  // Saturating count of aborted words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            frame_err_q <= '0;
    else if (restart && frame_err_q != '1) frame_err_q <= frame_err_q + ERR_W'(1);
  end

  deser_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (complete),
    .load_data  ({bus.din, collect_q[WIDTH-2:0]}),
    .dout_ready (bus.dout_ready),
    .dout       (dout_w),
    .dout_valid (dout_valid_w)
  );

  assign bus.din_ready  = din_ready;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_w;
  assign bus.dout_valid = dout_valid_w;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_demux1to16_deserializer.sv
// Directed bench for the 1:16 deserializer: loopback, sync, stall, restart, saturation, async reset.
module tb_demux1to16_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux1to16_deserializer_if #(.WIDTH(16), .SEL_W(4), .ERR_W(8)) bus ();

  demux1to16_deserializer #(.WIDTH(16), .SEL_W(4), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one bit, wait (bounded) for din_ready, let one edge accept it.
  // Returns at edge+1 with din_valid low.
  task automatic send_beat(input logic b, input logic fs);
    int n = 0;
    bus.din = b; bus.din_valid = 1'b1; bus.frame_start = fs;
    #0;
    while (!bus.din_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.din_ready) chk("beat_timeout", 32'(bus.din_ready), 32'd1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic fs_first);
    for (int k = 0; k < 16; k++) send_beat(w[k], fs_first && (k == 0));
  endtask

  logic [15:0] mux_in;
  logic [15:0] w;

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_start = 1'b0; bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",       32'(bus.sel),        32'd0);
    chk("rst_dout",      32'(bus.dout),       32'd0);
    chk("rst_dvalid",    32'(bus.dout_valid), 32'd0);
    chk("rst_ferr",      32'(bus.frame_err),  32'd0);
    chk("rst_din_ready", 32'(bus.din_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pre-sync drop: unframed bits in IDLE are ignored.
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(1'b1, 1'b0);
    chk("drop_sel",    32'(bus.sel),        32'd0);
    chk("drop_dvalid", 32'(bus.dout_valid), 32'd0);
    send_word(16'h1234, 1'b1);
    chk("sync_dout",   32'(bus.dout),       32'h1234);
    chk("sync_dvalid", 32'(bus.dout_valid), 32'd1);
    chk("sync_sel",    32'(bus.sel),        32'd0);
    @(posedge clk); #1;
    chk("sync_consumed", 32'(bus.dout_valid), 32'd0);

    // Loopback from a 16:1 mux scanning sel 0..15.
    mux_in = 16'b1010101010101010;
    for (int s = 0; s < 15; s++) send_beat(mux_in[s], s == 0);
    chk("loop_pre_valid", 32'(bus.dout_valid), 32'd0);
    chk("loop_sel15",     32'(bus.sel),        32'd15);
    send_beat(mux_in[15], 1'b0);
    chk("loop_dout",   32'(bus.dout),       32'hAAAA);
    chk("loop_dvalid", 32'(bus.dout_valid), 32'd1);
    chk("loop_ferr",   32'(bus.frame_err),  32'd0);
    @(posedge clk); #1;

    // Back-to-back with stall.
    bus.dout_ready = 1'b0;
    send_word(16'hFFFF, 1'b1);
    chk("b2b_first", 32'(bus.dout), 32'hFFFF);
    w = 16'h0F0F;
    for (int k = 0; k < 15; k++) send_beat(w[k], 1'b0);
    bus.din = w[15]; bus.din_valid = 1'b1; bus.frame_start = 1'b0;
    #1;
    chk("stall_ready", 32'(bus.din_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_sel",   32'(bus.sel),        32'd15);
      chk("stall_dout",  32'(bus.dout),       32'hFFFF);
      chk("stall_ready_hold", 32'(bus.din_ready), 32'd0);
    end
    bus.dout_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(bus.din_ready), 32'd1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    chk("b2b_dout",   32'(bus.dout),       32'h0F0F);
    chk("b2b_dvalid", 32'(bus.dout_valid), 32'd1);
    chk("b2b_sel",    32'(bus.sel),        32'd0);
    @(posedge clk); #1;
    chk("b2b_consumed", 32'(bus.dout_valid), 32'd0);

    // Early restart at sel=7.
    for (int k = 0; k < 7; k++) send_beat(1'b1, k == 0);
    chk("er_sel7", 32'(bus.sel), 32'd7);
    w = 16'hC3A5;
    send_beat(w[0], 1'b1);
    chk("er_ferr", 32'(bus.frame_err), 32'd1);
    chk("er_sel1", 32'(bus.sel),       32'd1);
    for (int k = 1; k < 16; k++) send_beat(w[k], 1'b0);
    chk("er_dout",   32'(bus.dout),       32'hC3A5);
    chk("er_dvalid", 32'(bus.dout_valid), 32'd1);
    chk("er_ferr2",  32'(bus.frame_err),  32'd1);
    @(posedge clk); #1;

    // Saturation: legal framed start at sel=0, then 260 restarts at sel=1.
    send_beat(1'b1, 1'b1);
    chk("sat_legal", 32'(bus.frame_err), 32'd1);
    for (int i = 0; i < 260; i++) begin
      send_beat(1'b0, 1'b1);
      if (i == 252) chk("sat_254", 32'(bus.frame_err), 32'd254);
    end
    chk("sat_255", 32'(bus.frame_err), 32'd255);
    chk("sat_sel", 32'(bus.sel),       32'd1);

    // Async reset mid-cycle at sel=9 with a held word.
    bus.dout_ready = 1'b0;
    for (int k = 1; k < 16; k++) send_beat(1'b1, 1'b0);
    chk("ar_dvalid", 32'(bus.dout_valid), 32'd1);
    chk("ar_dout",   32'(bus.dout),       32'hFFFE);
    for (int k = 0; k < 9; k++) send_beat(1'b1, 1'b0);
    chk("ar_sel9", 32'(bus.sel), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("ar_sel",    32'(bus.sel),        32'd0);
    chk("ar_dv",     32'(bus.dout_valid), 32'd0);
    chk("ar_do",     32'(bus.dout),       32'd0);
    chk("ar_ferr",   32'(bus.frame_err),  32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b0);
    chk("ar_resync_sel", 32'(bus.sel), 32'd0);
    send_word(16'h5A3C, 1'b1);
    chk("ar_word",   32'(bus.dout),       32'h5A3C);
    chk("ar_wvalid", 32'(bus.dout_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
